bytewrite_sp_ram_arbiter: RTL and testbench
===========================================

// Module: bytewrite_sp_ram_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of one byte-write, write-first, single-port RAM.
//  Accepts one valid/ready request per cycle and drives the RAM ena/we/addr/din pins.
//  Returns read data to the winner with fixed 1-cycle latency.
//  Supports a lock so one requester can own the RAM for back-to-back beats (read-modify-write).
// PARAMETERS
//  NUM_COL     4                   byte columns per word
//  COL_WIDTH   8                   bits per column
//  ADDR_WIDTH  10                  RAM address bits (depth 2**ADDR_WIDTH = 1024)
//  DATA_WIDTH  NUM_COL*COL_WIDTH   word width (derived, not overridden)
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  rst_n      in   1           synchronous, active-low reset
//  m0_valid   in   1           requester 0 request valid
//  m0_ready   out  1           requester 0 request accepted this cycle
//  m0_lock    in   1           requester 0 keeps ownership after this beat
//  m0_we      in   NUM_COL     byte write enables (0 = read)
//  m0_addr    in   ADDR_WIDTH  word address
//  m0_wdata   in   DATA_WIDTH  write data
//  m0_rvalid  out  1           response valid (registered)
//  m0_rdata   out  DATA_WIDTH  response data
//  m1_*       --   --          identical set for requester 1
//  ram_ena    out  1           RAM enable
//  ram_we     out  NUM_COL     RAM byte write enables
//  ram_addr   out  ADDR_WIDTH  RAM address
//  ram_din    out  DATA_WIDTH  RAM write data
//  ram_dout   in   DATA_WIDTH  RAM read data (valid 1 cycle after ena)
// BEHAVIOUR
//  - FSM states: IDLE, OWN0, OWN1. Reset -> IDLE, last_grant=1 (m0 wins the first contention).
//  - IDLE: only one valid -> grant it. Both valid -> grant !last_grant. Neither valid -> ram_ena=0.
//  - Grant is combinational the same cycle: mX_ready=1, ram_ena=1, ram_* = mX_* fields.
//  - ram_we forced to 0 whenever ram_ena=0. Grant and ready are one-hot or zero.
//  - Grant with mX_lock=1 -> next state OWNX. Grant with lock=0 -> IDLE. last_grant <= X on every grant.
//  - OWNX: only X may be granted; the other requester sees ready=0 even if X is idle.
//  - OWNX exit: granted beat with lock=0, or a cycle with mX_valid=0 and mX_lock=0 -> IDLE.
//  - Response: mX_rvalid <= granted-to-X (registered), asserted exactly 1 cycle after acceptance for reads and writes.
//  - mX_rdata = ram_dout while rvalid=1; holds last value otherwise.
//  - Write beats return the write-first word. Partial we returns the merged word.
//  - No response backpressure: requester must sink rvalid.
//  - Back-to-back: 1 accept/cycle sustained; rvalid may be high every cycle.
//  - Reset (rst_n=0 at edge, incl. mid-lock or in-flight): state IDLE, last_grant=1, both rvalid=0, rdata=0.
//    Combinational ready/ram_ena = 0 while rst_n=0. An in-flight response is dropped.
//  - Fairness: with both valid and no lock, grants alternate strictly 0,1,0,1...
//  - Address/data are not range-checked; widths pass straight through, with no arithmetic.
// STRUCTURE
//  - Shared package bytewrite_ram_pkg: owner_e enum {IDLE, OWN0, OWN1};
//    localparams NUM_COL, COL_WIDTH, ADDR_WIDTH, DATA_WIDTH defaults.
//  - Sub-module rr_arb2: 2-way round-robin with last_grant register and lock/hold input.
//  - Top: request mux, RAM pin drive, response demux registers.
//  - The RAM itself is instantiated outside, one level up.
// TESTING (bench wraps arbiter + bytewrite_sp_ram_wf golden model, per-cycle compare)
//  1. After reset: m0 writes we=4'hF addr=5 din=32'hDEADBEEF -> m0_ready=1 same cycle.
//     Next cycle m0_rvalid=1, m0_rdata=32'hDEADBEEF, m1_rvalid=0.
//  2. Both valid, no lock, 4 cycles, reads addr 5 -> grants 0,1,0,1.
//     Each rvalid 1 cycle later, rdata=32'hDEADBEEF.
//  3. m1 locks: 3 beats lock=1,1,0 while m0 valid throughout -> m0_ready=0 for 3 cycles.
//     m0 granted on the 4th cycle.
//  4. Partial write: m1 we=4'b0101 din=32'h11223344 to addr 5 -> m1_rdata=32'hDE22BE44.
//     A later read of addr 5 returns the same word.
//  5. rst_n=0 while in OWN0 with a read in flight -> next cycle rvalid=0, rdata=0, ram_ena=0.
//     After release, m1 alone valid is granted immediately.
//  6. 1024 random cycles (random valid/lock/we/addr/data): 0 mismatches vs scoreboard.
//     Never both ready; ram_we=0 whenever ram_ena=0.

Source files
------------

// File: rtl/bytewrite_ram_pkg.sv
// Shared types and default geometry for the byte-write RAM arbiter slice.
// The RAM word is NUM_COL byte columns of COL_WIDTH bits each.
package bytewrite_ram_pkg;

    localparam int NUM_COL    = 4;
    localparam int COL_WIDTH  = 8;
    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

endpackage

// File: rtl/bytewrite_sp_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with an ownership lock.
// The grant is combinational. The owner state and last_grant update on posedge.
module rr_arb2
    import bytewrite_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    owner_e state_q;
    owner_e state_d;
    logic   last_grant_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (|gnt) begin
                last_grant_q <= gnt[1];
            end
        end
    end

    // An owner keeps the RAM for exactly as long as it holds lock, whether or not it is granted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt[0]) begin
                    state_d = lock[0] ? OWN0 : IDLE;
                end else if (gnt[1]) begin
                    state_d = lock[1] ? OWN1 : IDLE;
                end
            end
            OWN0:    state_d = lock[0] ? OWN0 : IDLE;
            OWN1:    state_d = lock[1] ? OWN1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (req[0] && req[1]) begin
                        gnt = last_grant_q ? 2'b01 : 2'b10;
                    end else begin
                        gnt = req;
                    end
                end
                OWN0:    gnt = {1'b0, req[0]};
                OWN1:    gnt = {req[1], 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/bytewrite_sp_ram_arbiter.sv
// Round-robin sequencer that lets two requesters share one write-first, byte-write RAM.
// Requests are accepted combinationally. Each accepted request gets its response exactly one cycle later.
module bytewrite_sp_ram_arbiter
    import bytewrite_ram_pkg::*;
#(
    parameter int NUM_COL    = bytewrite_ram_pkg::NUM_COL,
    parameter int COL_WIDTH  = bytewrite_ram_pkg::COL_WIDTH,
    parameter int ADDR_WIDTH = bytewrite_ram_pkg::ADDR_WIDTH,
    localparam int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_lock,
    input  logic [NUM_COL-1:0]    m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_lock,
    input  logic [NUM_COL-1:0]    m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_ena,
    output logic [NUM_COL-1:0]    ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic [1:0]            gnt;
    logic [1:0]            rvalid_p1;
    logic [DATA_WIDTH-1:0] hold0_p1;
    logic [DATA_WIDTH-1:0] hold1_p1;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({m1_valid, m0_valid}),
        .lock  ({m1_lock, m0_lock}),
        .gnt   (gnt)
    );

    assign m0_ready = gnt[0];
    assign m1_ready = gnt[1];
    assign ram_ena  = |gnt;

    // Address and data follow the granted requester. Write enables are gated so an idle RAM is never written.
    always_comb begin
        ram_addr = gnt[1] ? m1_addr  : m0_addr;
        ram_din  = gnt[1] ? m1_wdata : m0_wdata;
        ram_we   = '0;
        if (gnt[0]) begin
            ram_we = m0_we;
        end else if (gnt[1]) begin
            ram_we = m1_we;
        end
    end

    // Response stage: the RAM output is valid one cycle after ena. The last word is held for each requester.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_p1 <= 2'b00;
            hold0_p1  <= '0;
            hold1_p1  <= '0;
        end else begin
            rvalid_p1 <= gnt;
            if (rvalid_p1[0]) begin
                hold0_p1 <= ram_dout;
            end
            if (rvalid_p1[1]) begin
                hold1_p1 <= ram_dout;
            end
        end
    end

    assign m0_rvalid = rvalid_p1[0];
    assign m1_rvalid = rvalid_p1[1];
    assign m0_rdata  = rvalid_p1[0] ? ram_dout : hold0_p1;
    assign m1_rdata  = rvalid_p1[1] ? ram_dout : hold1_p1;

endmodule

// File: tb/tb_bytewrite_sp_ram_arbiter.sv
// Bench for the arbiter wrapped around a behavioural write-first byte-write RAM.
// A reference arbiter and a shadow memory predict every cycle's grant and every response.
module tb_bytewrite_sp_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_valid, m0_ready, m0_lock, m0_rvalid;
    logic [3:0]  m0_we;
    logic [9:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_valid, m1_ready, m1_lock, m1_rvalid;
    logic [3:0]  m1_we;
    logic [9:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        ram_ena;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          who;
        logic [31:0] data;
    } ent_t;
    ent_t sbq[$];

    logic [31:0] mem [1024];
    logic [31:0] sm  [1024];
    int          ms;
    logic        mlast;
    logic [31:0] exp_hold0, exp_hold1;

    always #5 clk = ~clk;

    bytewrite_sp_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_lock(m0_lock), .m0_we(m0_we),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_lock(m1_lock), .m1_we(m1_we),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] din,
                                           input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int c = 0; c < 4; c++) begin
            if (we[c]) r[c*8 +: 8] = din[c*8 +: 8];
        end
        return r;
    endfunction

    // Write-first byte-write single-port RAM
    always @(posedge clk) begin
        if (ram_ena) begin
            mem[ram_addr] <= wmerge(mem[ram_addr], ram_din, ram_we);
            ram_dout      <= wmerge(mem[ram_addr], ram_din, ram_we);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        if (!rst_n) return -1;
        if (ms == 1) return m0_valid ? 0 : -1;
        if (ms == 2) return m1_valid ? 1 : -1;
        if (m0_valid && m1_valid) return mlast ? 0 : 1;
        if (m0_valid) return 0;
        if (m1_valid) return 1;
        return -1;
    endfunction

    task automatic cycle();
        ent_t        e, n;
        int          g;
        logic        lk, rs;
        logic [9:0]  a;
        logic [3:0]  w;
        logic [31:0] d;
        @(negedge clk);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.who == 0) exp_hold0 = e.data;
            if (e.who == 1) exp_hold1 = e.data;
            chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, e.who == 0});
            chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, e.who == 1});
        end
        chk("m0_rdata", m0_rdata, exp_hold0);
        chk("m1_rdata", m1_rdata, exp_hold1);
        g  = exp_grant();
        rs = rst_n;
        chk("m0_ready", {31'b0, m0_ready}, {31'b0, g == 0});
        chk("m1_ready", {31'b0, m1_ready}, {31'b0, g == 1});
        chk("ram_ena", {31'b0, ram_ena}, {31'b0, g >= 0});
        a  = (g == 1) ? m1_addr : m0_addr;
        w  = (g == 1) ? m1_we : m0_we;
        d  = (g == 1) ? m1_wdata : m0_wdata;
        lk = (g == 1) ? m1_lock : m0_lock;
        chk("ram_we", {28'b0, ram_we}, (g >= 0) ? {28'b0, w} : 32'b0);
        n.who  = g;
        n.data = '0;
        if (g >= 0) begin
            chk("ram_addr", {22'b0, ram_addr}, {22'b0, a});
            chk("ram_din", ram_din, d);
            sm[a]  = wmerge(sm[a], d, w);
            n.data = sm[a];
        end
        sbq.push_back(n);
        @(posedge clk);
        #1;
        if (!rs) begin
            ms = 0; mlast = 1'b1; exp_hold0 = '0; exp_hold1 = '0;
        end else if (g >= 0) begin
            mlast = (g == 1);
            ms    = lk ? g + 1 : 0;
        end else if (ms == 1) begin
            ms = m0_lock ? 1 : 0;
        end else if (ms == 2) begin
            ms = m1_lock ? 2 : 0;
        end
    endtask

    task automatic set0(input logic v, input logic l, input logic [3:0] w,
                        input logic [9:0] a, input logic [31:0] d);
        m0_valid = v; m0_lock = l; m0_we = w; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic l, input logic [3:0] w,
                        input logic [9:0] a, input logic [31:0] d);
        m1_valid = v; m1_lock = l; m1_we = w; m1_addr = a; m1_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            sm[i]  = '0;
        end
        rst_n = 1'b0;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        ms = 0; mlast = 1'b1; exp_hold0 = '0; exp_hold1 = '0;
        rst_n = 1'b1;

        // Reset state: idle, no responses, zero data
        cycle();

        // Full write by m0, write-first response next cycle
        set0(1, 0, 4'hF, 10'd5, 32'hDEADBEEF);
        #1 chk("t1_m0_ready", {31'b0, m0_ready}, 32'd1);
        cycle();
        set0(0, 0, 0, 0, 0);
        chk("t1_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
        chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("t1_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);

        // m1 single read so the next contention starts with m0
        set1(1, 0, 0, 10'd5, 0);
        cycle();

        // Contention, no lock: grants alternate 0,1,0,1
        set0(1, 0, 0, 10'd5, 0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_m0_ready", {31'b0, m0_ready}, {31'b0, (i % 2) == 0});
            cycle();
        end
        chk("t2_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
        chk("t2_m1_rdata", m1_rdata, 32'hDEADBEEF);

        // m0 alone, then m1 locks three beats while m0 keeps requesting
        set1(0, 0, 0, 0, 0);
        cycle();
        set1(1, 1, 0, 10'd5, 0);
        #1 chk("t3_m0_blk0", {31'b0, m0_ready}, 32'd0);
        cycle();
        #1 chk("t3_m0_blk1", {31'b0, m0_ready}, 32'd0);
        cycle();
        set1(1, 0, 0, 10'd5, 0);
        #1 chk("t3_m0_blk2", {31'b0, m0_ready}, 32'd0);
        cycle();
        set1(0, 0, 0, 0, 0);
        #1 chk("t3_m0_win", {31'b0, m0_ready}, 32'd1);
        cycle();

        // Partial write by m1 returns the merged word, then a read confirms it
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 4'b0101, 10'd5, 32'h11223344);
        cycle();
        chk("t4_m1_rdata_wr", m1_rdata, 32'hDE22BE44);
        set1(1, 0, 0, 10'd5, 0);
        cycle();
        chk("t4_m1_rdata_rd", m1_rdata, 32'hDE22BE44);

        // Reset while m0 owns the RAM with a read in flight
        set1(0, 0, 0, 0, 0);
        set0(1, 1, 0, 10'd5, 0);
        cycle();
        rst_n = 1'b0;
        #1 chk("t5_ena_in_rst", {31'b0, ram_ena}, 32'd0);
        cycle();
        rst_n = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 0, 10'd7, 0);
        #1;
        chk("t5_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
        chk("t5_m0_rdata", m0_rdata, 32'd0);
        chk("t5_m1_ready", {31'b0, m1_ready}, 32'd1);
        cycle();

        // Random traffic against the reference model
        for (int i = 0; i < 1024; i++) begin
            set0($urandom_range(0, 1), $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0,
                 10'($urandom_range(0, 7)), $urandom);
            set1($urandom_range(0, 1), $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0,
                 10'($urandom_range(0, 7)), $urandom);
            #1 chk("rnd_onehot", {31'b0, m0_ready && m1_ready}, 32'd0);
            cycle();
        end

        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
